// File: rtl/serial_addsub.sv
// Chunk-serial add/subtract with valid/ready handshakes and status flags.
// Define SERIAL_ADDSUB_SAT_EN to build the signed saturation path.
module serial_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q, sub_q;
  logic [IW-1:0]    idx_q;
  logic             cy_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q, ovf_q, zero_q, neg_q;

  logic [CHUNK-1:0] a_ch, b_ch, b_x;
  logic             cy_i;
  logic [CHUNK:0]   sum;
  logic             c_msb, ovf_d, last;
  logic [WIDTH-1:0] res_mod, res_fin;

`ifdef SERIAL_ADDSUB_SAT_EN
  logic sat_q;
`else
  logic unused_sat;
  assign unused_sat = sat;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign negative  = neg_q;

  assign last = (idx_q == IW'(N - 1));

  // One CHUNK-wide slice serves every chunk position.
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int j = 0; j < N; j++) begin
      if (idx_q == IW'(j)) begin
        a_ch = a_q[j*CHUNK +: CHUNK];
        b_ch = b_q[j*CHUNK +: CHUNK];
      end
    end
    b_x   = sub_q ? ~b_ch : b_ch;
    cy_i  = (idx_q == '0) ? (sub_q ^ cin_q) : cy_q;
    sum   = {1'b0, a_ch} + {1'b0, b_x} + {{CHUNK{1'b0}}, cy_i};
    c_msb = sum[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_x[CHUNK-1];
    ovf_d = c_msb ^ sum[CHUNK];
  end

  always_comb begin
    res_mod = res_q;
    for (int j = 0; j < N; j++) begin
      if (idx_q == IW'(j)) begin
        res_mod[j*CHUNK +: CHUNK] = sum[CHUNK-1:0];
      end
    end
    res_fin = res_mod;
`ifdef SERIAL_ADDSUB_SAT_EN
    // On overflow the true sign always equals A's sign.
    if (sat_q && ovf_d) begin
      res_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sub_q   <= 1'b0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        a_q   <= a;
        b_q   <= b;
        cin_q <= c_in;
        sub_q <= sub;
        idx_q <= '0;
        cy_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_SAT_EN
        sat_q <= sat;
`endif
      end
      if (state_q == RUN) begin
        cy_q <= sum[CHUNK];
        if (last) begin
          idx_q   <= '0;
          res_q   <= res_fin;
          carry_q <= sum[CHUNK];
          ovf_q   <= ovf_d;
          zero_q  <= (res_fin == '0);
          neg_q   <= res_fin[WIDTH-1];
        end else begin
          idx_q <= idx_q + 1'b1;
          res_q <= res_mod;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Randomised and directed bench for serial_addsub (WIDTH=32, CHUNK=8).
// Expectations come from plain signed/unsigned arithmetic.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready;
  logic [31:0] a, b, result;
  logic        c_in, sub, sat;
  logic        out_valid, out_ready;
  logic        carry, overflow, zero, negative;

  int total = 0;
  int bad   = 0;

  serial_addsub #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow),
    .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic        cy, ov, z, n;
  } exp_t;

  function automatic exp_t model(logic [31:0] x, logic [31:0] y,
                                 logic ci, logic s, logic st);
    exp_t   e;
    longint t;
    longint ux, uy;
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    t  = s ? longint'($signed(x)) - longint'($signed(y)) - longint'(ci)
           : longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    e.ov  = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    e.cy  = s ? (ux >= uy + longint'(ci))
              : (ux + uy + longint'(ci) > 64'd4294967295);
    e.res = s ? 32'(ux - uy - longint'(ci))
              : 32'(ux + uy + longint'(ci));
`ifdef SERIAL_ADDSUB_SAT_EN
    if (st && e.ov) e.res = (t < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    if (st) e.res = e.res;
`endif
    e.z = (e.res == 32'd0);
    e.n = e.res[31];
    return e;
  endfunction

  task automatic do_op(input string tg, input logic [31:0] x,
                       input logic [31:0] y, input logic ci,
                       input logic s, input logic st,
                       input int hold, input bit pulse);
    exp_t e;
    int   n;
    e = model(x, y, ci, s, st);
    @(negedge clk);
    chk({tg, ".rdy"}, 32'(in_ready), 32'd1);
    a = x; b = y; c_in = ci; sub = s; sat = st;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; c_in = 1'b1; sub = ~s; sat = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tg, ".lat"}, 32'(n), 32'd4);
    chk({tg, ".res"}, result, e.res);
    chk({tg, ".cy"}, 32'(carry), 32'(e.cy));
    chk({tg, ".ov"}, 32'(overflow), 32'(e.ov));
    chk({tg, ".z"}, 32'(zero), 32'(e.z));
    chk({tg, ".n"}, 32'(negative), 32'(e.n));
    for (int i = 0; i < hold; i++) begin
      in_valid = pulse && (i == 1);
      a = 32'h1234_5678; b = 32'h0BAD_F00D;
      @(negedge clk);
      chk({tg, ".hres"}, result, e.res);
      chk({tg, ".hflg"}, {28'd0, carry, overflow, zero, negative},
          {28'd0, e.cy, e.ov, e.z, e.n});
      chk({tg, ".hrdy"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tg, ".irdy"}, 32'(in_ready), 32'd1);
    chk({tg, ".ovld"}, 32'(out_valid), 32'd0);
    if (pulse) begin
      repeat (6) begin
        @(negedge clk);
        chk({tg, ".ghost"}, 32'(out_valid), 32'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0; sat = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst.res", result, 32'd0);
    chk("rst.flg", {27'd0, carry, overflow, zero, negative, out_valid},
        {27'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    chk("rst.rdy", 32'(in_ready), 32'd1);

    do_op("wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    do_op("borrow", 32'd5, 32'd7, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    do_op("bin", 32'd10, 32'd3, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    do_op("ovsat", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    do_op("negsat", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    do_op("bp", 32'h0000_FF00, 32'h0000_0100, 1'b1, 1'b0, 1'b0,
          5, 1'b1);

    // Abort an operation after two chunks have been computed.
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; c_in = 1'b1; sub = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.res", result, 32'd0);
    chk("abort.flg", {27'd0, carry, overflow, zero, negative, out_valid},
        {27'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    chk("abort.rdy", 32'(in_ready), 32'd1);
    repeat (6) begin
      @(negedge clk);
      chk("abort.ovld", 32'(out_valid), 32'd0);
    end
    do_op("post", 32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = (k % 4 == 0) ? ~x : $urandom;
      do_op($sformatf("rnd%0d", k), x, y, 1'($urandom), 1'($urandom),
            1'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair CHUNK bits per clock, LSB chunk first, through a single CHUNK-bit carry-propagate slice. It is the area-optimised, handshaked successor to the flat ripple adder/subtractor. It adds signed/unsigned status flags and optional signed saturation, and sits between operand-producing and result-consuming stages on valid/ready interfaces.

## Interface
- WIDTH, 32, operand/result width; must be a positive multiple of CHUNK
- CHUNK, 8, bits processed per cycle; N = WIDTH/CHUNK cycles per operation (CHUNK == WIDTH gives N = 1)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand request
- in_ready  output  1  block can accept an operand pair
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry-in for add; borrow-in for subtract
- sub  input  1  0 = A+B+c_in, 1 = A-B-c_in
- sat  input  1  saturation request; see Configuration
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  sum/difference
- carry  output  1  carry out of MSB; in subtract, 1 = no borrow
- overflow  output  1  signed (two's-complement) overflow of unsaturated result
- zero  output  1  result == 0, after saturation
- negative  output  1  result MSB, after saturation

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, register a, b, c_in, sub and sat, then go to RUN with chunk index 0.
- RUN:
  - Each cycle computes one chunk as a[i] + (sub ? ~b[i] : b[i]) + cy.
  - For chunk 0, cy = sub ? ~c_in : c_in. For later chunks, cy is the registered carry from the previous chunk.
  - The sum chunk is written into the result register at position i.
  - After chunk N-1, finalise the flags and apply saturation, then go to DONE.
- DONE:
  - out_valid = 1.
  - On out_valid & out_ready, go to IDLE.
- Subtract semantics: result = (A − B − c_in) mod 2^WIDTH.
- overflow = carry into MSB XOR carry out of MSB, taken from the final chunk.
- Inputs are ignored outside the IDLE accept cycle. Operand changes after acceptance have no effect.
- result and flags hold stable while out_valid = 1 and out_ready = 0.
- in_ready = 0 in RUN and DONE. in_valid asserted there is neither captured nor queued.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - result = 0, carry = 0, overflow = 0, negative = 0.
  - zero = 1, consistent with result = 0.
  - Internal carry and chunk index = 0.
- Latency, with acceptance at edge k:
  - Chunks are computed at edges k+1 … k+N.
  - out_valid rises after edge k+N.
- Output handshake and throughput:
  - An out handshake at edge m gives in_ready = 1 after m.
  - The next accept is at m+1 at the earliest.
  - Sustained throughput with out_ready held high is one operation per N+2 cycles.
- Reset in any state, including mid-RUN:
  - Aborts the operation and discards its partial result.
  - All outputs return to reset values on the next edge. No out_valid is produced for the aborted operation.
- rst has priority over any simultaneous handshake.
- Chunk index wraps only by returning to IDLE. It never exceeds N-1.

## Configuration
- Macro: SERIAL_ADDSUB_SAT_EN.
- Defined:
  - When the captured sat = 1 and overflow = 1, result clamps to the signed limit of the true result's sign.
  - If A's MSB is 0, result = 0x7FF…F. If A's MSB is 1, result = 0x800…0.
  - overflow and carry still report the unsaturated computation. zero and negative reflect the clamped result.
- Not defined:
  - The sat port is present but ignored, and no saturation logic is synthesised.
  - result is always the modular value.

## Test plan
WIDTH=32, CHUNK=8, so N=4.
- **Add with wrap:** a=0xFFFFFFFF, b=1, c_in=0, sub=0 → result=0, carry=1, zero=1, overflow=0; out_valid exactly 4 cycles after the accept edge.
- **Subtract with borrow:** a=5, b=7, sub=1, c_in=0 → result=0xFFFFFFFE, carry=0, negative=1, overflow=0.
- **Subtract with borrow-in:** a=10, b=3, sub=1, c_in=1 → result=6, carry=1.
- **Overflow and saturation:** a=0x7FFFFFFF, b=1, add, sat=1.
  - Without the macro: result=0x80000000, overflow=1, negative=1.
  - With the macro: result=0x7FFFFFFF, overflow=1, negative=0.
- **Back-pressure:** hold out_ready=0 for 5 cycles after out_valid, and pulse in_valid with new operands during that window → result and flags stay unchanged, in_ready stays 0, and the pulsed operands are never processed. Then raise out_ready → in_ready=1 one cycle later.
- **Reset mid-operation:** assert rst for one cycle after 2 chunks of RUN → outputs at reset values next cycle with no out_valid. A following op a=3, b=4, add → result=7.
